// File: rtl/st7735_pkg.sv
// Shared types, ST7735 command bytes and a one-hot helper for the SPI arbiter slice.
package st7735_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    XFER,
    HOLD
  } arb_state_t;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/st7735_spi_arbiter_rr.sv
// Combinational round-robin pick: first requesting lane at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int PW = $clog2(N);

  logic [PW:0] pos;
  logic        found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    for (int off = 0; off < N; off++) begin
      pos = {1'b0, ptr} + (PW+1)'(off);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!found && req[pos[PW-1:0]]) begin
        gnt[pos[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/st7735_spi_arbiter.sv
// Burst arbiter sharing one SPI byte engine between NUM_REQ requesters; owns TFT CS/DC.
// Optional stall timeout with abort pulse: define ST7735_SPI_ARB_TIMEOUT_EN.
module st7735_spi_arbiter
  import st7735_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int CS_SETUP_CYCLES = 2,
  parameter int CS_HOLD_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_dc,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 spi_start,
  output logic [7:0]           spi_data,
  input  logic                 spi_busy,
  input  logic                 spi_done,
  output logic                 tft_cs,
  output logic                 tft_dc,
  output logic                 abort
);

  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYCLES - 1);
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || CS_SETUP_CYCLES < 1 || CS_HOLD_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("st7735_spi_arbiter: parameter out of range");
  end

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               cs_q, cs_d;
  logic               dc_q, dc_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d;
  logic               start_q, start_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] pick;
  logic               take;

  logic [7:0] lane_data [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_data[i] = req_data[8*i +: 8];
  end

  logic       sel_valid, sel_dc, sel_last;
  logic [7:0] sel_data;
  assign sel_valid = req_valid[gidx_q];
  assign sel_dc    = req_dc[gidx_q];
  assign sel_last  = req_last[gidx_q];
  assign sel_data  = lane_data[gidx_q];

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick)
  );

`ifdef ST7735_SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            abort_q, abort_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      abort_q <= abort_d;
    end
  end

  assign abort = abort_q;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      start_q <= 1'b0;
      ready_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
      data_q  <= data_d;
      last_q  <= last_d;
      start_q <= start_d;
      ready_q <= ready_d;
    end
  end

  // The last SETUP cycle may already accept a byte so the first start lands exactly
  // CS_SETUP_CYCLES after CS falls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cs_d    = cs_q;
    dc_d    = dc_q;
    data_d  = data_q;
    last_d  = last_q;
    start_d = 1'b0;
    ready_d = '0;
    take    = 1'b0;
`ifdef ST7735_SPI_ARB_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    abort_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = pick;
          gidx_d  = PTR_W'(onehot_to_idx(8'(pick)));
          cs_d    = 1'b0;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = LOAD;
          take    = sel_valid && !spi_busy;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        take = sel_valid && !spi_busy;
`ifdef ST7735_SPI_ARB_TIMEOUT_EN
        if (!sel_valid) begin
          if (tcnt_q == TO_LAST) begin
            abort_d = 1'b1;
            tcnt_d  = '0;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
`endif
      end
      XFER: begin
        if (spi_done) begin
          cnt_d   = '0;
          state_d = last_q ? HOLD : LOAD;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cs_d    = 1'b1;
          grant_d = '0;
          ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      start_d = 1'b1;
      ready_d = grant_q;
      data_d  = sel_data;
      dc_d    = sel_dc;
      last_d  = sel_last;
      state_d = XFER;
`ifdef ST7735_SPI_ARB_TIMEOUT_EN
      tcnt_d  = '0;
`endif
    end
  end

  assign req_ready = ready_q;
  assign grant     = grant_q;
  assign spi_start = start_q;
  assign spi_data  = data_q;
  assign tft_cs    = cs_q;
  assign tft_dc    = dc_q;

endmodule

// File: doc/st7735_spi_arbiter.md
Name: st7735_spi_arbiter

Overview:
- Shares one spi_controller byte engine between NUM_REQ byte-stream requesters, e.g. init/command sequencer (req 0) and pixel streamer (req 1).
- Owns the TFT chip-select and data/command pins. Holds CS low for a whole burst and drives DC per byte.
- Grants whole bursts, terminated by req_last, using round-robin priority.
- Sits between the requesters and spi_controller, replacing direct spi_start/spi_data driving by the panel controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- CS_SETUP_CYCLES, 2, clk cycles from CS falling to first spi_start (>=1)
- CS_HOLD_CYCLES, 2, clk cycles from last spi_done to CS rising (>=1)
- TIMEOUT_CYCLES, 4096, stall limit inside a burst (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  requester i has a byte on its lane
- req_data  in  NUM_REQ*8  byte lanes; lane i is bits [8i+7:8i]
- req_dc  in  NUM_REQ  per-lane DC: 0 = command, 1 = data
- req_last  in  NUM_REQ  byte is the final byte of the burst
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted lane
- grant  out  NUM_REQ  one-hot owner of the current burst; 0 when idle
- spi_start  out  1  one-cycle start pulse to spi_controller
- spi_data  out  8  byte to spi_controller, stable from start until done
- spi_busy  in  1  from spi_controller
- spi_done  in  1  one-cycle pulse from spi_controller
- tft_cs  out  1  panel chip select, active low
- tft_dc  out  1  panel data/command select
- abort  out  1  one-cycle pulse when a burst is aborted (optional feature only, else tied 0)

Behaviour:
- Reset values (asynchronous, rst_n low): tft_cs=1, tft_dc=0, spi_start=0, spi_data=0, req_ready=0, grant=0, abort=0, state=IDLE, priority pointer=0.
- Reset asserted mid-burst: CS rises immediately; requesters restart their bursts.
- States: IDLE, SETUP, LOAD, XFER, HOLD.
- IDLE:
  - If any req_valid is high, choose the first lane at or after the priority pointer (wrapping).
  - Register grant one-hot, drive tft_cs=0, go to SETUP.
  - Arbitration uses req_valid only, so a grant is issued 1 cycle after req_valid rises.
- SETUP: count CS_SETUP_CYCLES, then go to LOAD.
- LOAD:
  - Stay while req_valid[g] is low; CS stays low.
  - Once req_valid[g] is high and spi_busy is low, in the same cycle:
    - pulse spi_start and req_ready[g];
    - latch spi_data=req_data[g], tft_dc=req_dc[g], last flag=req_last[g];
    - go to XFER.
  - Requester may change its lane on the cycle after req_ready.
- XFER:
  - Wait for spi_done.
  - Latched last=0: go to LOAD (next start no earlier than 1 cycle after done).
  - Latched last=1: go to HOLD.
  - tft_dc and spi_data must not change in XFER.
- HOLD:
  - Count CS_HOLD_CYCLES, then drive tft_cs=1, grant=0.
  - Priority pointer = (g+1) mod NUM_REQ. Go to IDLE.
  - Minimum 1 idle cycle with CS high between bursts.
- Other requesters' valid/last are ignored while a burst is in progress; no preemption.
- Simultaneous requests in IDLE: the pointer decides. After reset, lane 0 beats lane 1.
- spi_done outside XFER is ignored. spi_busy high in LOAD delays start.
- tft_dc is held at its last value between bytes and bursts.

Optional Feature:
- Macro ST7735_SPI_ARB_TIMEOUT_EN.
- Enabled:
  - A counter runs in LOAD while req_valid[g] is low; it clears on accept.
  - At TIMEOUT_CYCLES the arbiter pulses abort for 1 cycle, goes to HOLD, then releases CS and rotates priority.
- Disabled:
  - No counter. The arbiter waits in LOAD indefinitely; abort is tied 0.
  - TIMEOUT_CYCLES is unused.

Decomposition:
- Package st7735_pkg:
  - state enum arb_state_t (IDLE, SETUP, LOAD, XFER, HOLD);
  - command constants CMD_SWRESET=8'h01, CMD_SLPOUT=8'h11, CMD_COLMOD=8'h3A, CMD_MADCTL=8'h36, CMD_RAMWR=8'h2C, used by the bench and requesters.
- Sub-module rr_arbiter: combinational round-robin pick (req vector plus pointer in, one-hot out).
- The FSM and counters stay in st7735_spi_arbiter.

Test Plan:
- Single burst: req0 sends 01 (dc0, last0), 3A (dc0), 05 (dc1, last1).
  - Fake TFT captures (0,01), (0,3A), (1,05) with CS low throughout.
  - CS falls CS_SETUP_CYCLES before the first sclk; CS rises CS_HOLD_CYCLES after the last done.
- Contention: req0 and req1 raise valid on the same cycle with 2-byte bursts each.
  - Post-reset, req0's burst completes first, then req1's.
  - Next simultaneous request goes to req0 (pointer = 0 after req1).
- No preemption: req1 asserts valid mid-burst of req0.
  - req1's bytes appear only after CS goes high for at least 1 cycle; req0's bytes are never interleaved.
- Stall: req0 drops valid for 300 cycles between bytes.
  - CS stays low, no spi_start.
  - Transfer resumes within 1 cycle of valid returning (macro off, or TIMEOUT_CYCLES=4096).
- Timeout (macro on, TIMEOUT_CYCLES=50): req0 stalls after its first byte.
  - abort pulses once at stall cycle 50; CS rises after hold; req1 is granted next.
- Reset mid-XFER: rst_n low for 3 cycles.
  - tft_cs=1, grant=0 asynchronously.
  - After release, a fresh burst captures correctly from byte 0.
